// File: rtl/cpu_defs.sv
// Register-index and word-width definitions shared by the controller and the register file.
// The controller selects registers by name through these constants instead of raw literals.
package cpu_defs;

    localparam int WORD_W   = 16;
    localparam int SEL_W    = 3;
    localparam int NUM_REGS = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  reg_sel_t;

    localparam reg_sel_t REG_PC  = 3'd0;
    localparam reg_sel_t REG_LR  = 3'd1;
    localparam reg_sel_t REG_SP  = 3'd6;
    localparam reg_sel_t REG_TMP = 3'd7;

    // r0 and r6 live in dedicated counters rather than in the plain array
    function automatic logic is_counter_reg(reg_sel_t sel);
        return (sel == REG_PC) || (sel == REG_SP);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Controller <-> register file strobes plus the bus and ALU operand outputs of the register file.
// The controller side is the master; the register file is the slave.
interface register_file_if;
    import cpu_defs::*;

    word_t    in;
    reg_sel_t reg_src_sel;
    reg_sel_t reg_dst_sel;
    logic     reg_in_en;
    logic     reg_out_en;
    logic     reg_pc_inc;
    logic     sp_inc;
    logic     sp_dec;

    word_t    out;
    word_t    alu_a;
    word_t    alu_b;
    word_t    pc;
    word_t    sp;

    modport master (
        output in, reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en,
               reg_pc_inc, sp_inc, sp_dec,
        input  out, alu_a, alu_b, pc, sp
    );

    modport slave (
        input  in, reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en,
               reg_pc_inc, sp_inc, sp_dec,
        output out, alu_a, alu_b, pc, sp
    );

endinterface

// File: rtl/load_counter.sv
// Register with parallel load taking priority over increment/decrement, wrapping modulo 2^WIDTH.
// Updates on the rising edge, one-cycle latency; no backpressure. inc and dec together hold the value.
module load_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (inc && !dec) begin
            count_nxt = count + WIDTH'(1);
        end else if (dec && !inc) begin
            count_nxt = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VAL;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/register_file.sv
// Eight-entry 16-bit register file: r0 = PC and r6 = SP are load/step counters, the rest a plain array.
// Reads are combinational; writes and steps land on the rising edge with no bypass; no backpressure.
module register_file
    import cpu_defs::*;
#(
    parameter word_t RESET_PC  = 16'h0000,
    parameter word_t STACK_TOP = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    word_t pc_q;
    word_t sp_q;
    word_t gpr_q [NUM_REGS];
    word_t rd_a;
    word_t rd_b;
    logic  pc_load;
    logic  sp_load;

    // A bus write to r0/r6 outranks any step requested on the same edge
    assign pc_load = bus.reg_in_en && (bus.reg_dst_sel == REG_PC);
    assign sp_load = bus.reg_in_en && (bus.reg_dst_sel == REG_SP);

    load_counter #(
        .WIDTH     (WORD_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (bus.in),
        .inc      (bus.reg_pc_inc),
        .dec      (1'b0),
        .count    (pc_q)
    );

    load_counter #(
        .WIDTH     (WORD_W),
        .RESET_VAL (STACK_TOP)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .load     (sp_load),
        .load_val (bus.in),
        .inc      (bus.sp_inc),
        .dec      (bus.sp_dec),
        .count    (sp_q)
    );

    // Slots 0 and 6 of the array are never written; their contents come from the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (bus.reg_in_en && !is_counter_reg(bus.reg_dst_sel)) begin
            gpr_q[bus.reg_dst_sel] <= bus.in;
        end
    end

    always_comb begin
        rd_a = gpr_q[bus.reg_dst_sel];
        rd_b = gpr_q[bus.reg_src_sel];
        if (bus.reg_dst_sel == REG_PC) begin
            rd_a = pc_q;
        end else if (bus.reg_dst_sel == REG_SP) begin
            rd_a = sp_q;
        end
        if (bus.reg_src_sel == REG_PC) begin
            rd_b = pc_q;
        end else if (bus.reg_src_sel == REG_SP) begin
            rd_b = sp_q;
        end
    end

    assign bus.alu_a = rd_a;
    assign bus.alu_b = rd_b;
    assign bus.out   = bus.reg_out_en ? rd_b : 'z;
    assign bus.pc    = pc_q;
    assign bus.sp    = sp_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_if bus ();

    register_file #(
        .RESET_PC  (16'h0100),
        .STACK_TOP (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] m [8];
    logic [15:0] zval = 'z;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        m[0] = 16'h0100;
        m[6] = 16'hFFFF;
    endtask

    // Next architectural state from the rules: bus write first, then r0/r6 steps unless overwritten
    task automatic model_update();
        logic [15:0] nm [8];
        for (int i = 0; i < 8; i++) nm[i] = m[i];
        if (bus.reg_in_en) nm[bus.reg_dst_sel] = bus.in;
        if (bus.reg_pc_inc && !(bus.reg_in_en && bus.reg_dst_sel == 3'd0))
            nm[0] = 16'((m[0] + 17'd1) % 17'h10000);
        if ((bus.sp_inc != bus.sp_dec) && !(bus.reg_in_en && bus.reg_dst_sel == 3'd6))
            nm[6] = bus.sp_inc ? 16'((m[6] + 17'd1) % 17'h10000)
                               : 16'((m[6] + 17'h0FFFF) % 17'h10000);
        for (int i = 0; i < 8; i++) m[i] = nm[i];
    endtask

    task automatic check_all(input string tag);
        check({tag, "/pc"},    bus.pc,    m[0]);
        check({tag, "/sp"},    bus.sp,    m[6]);
        check({tag, "/alu_a"}, bus.alu_a, m[bus.reg_dst_sel]);
        check({tag, "/alu_b"}, bus.alu_b, m[bus.reg_src_sel]);
        check({tag, "/out"},   bus.out,   bus.reg_out_en ? m[bus.reg_src_sel] : zval);
    endtask

    task automatic set_idle();
        bus.reg_in_en  = 1'b0;
        bus.reg_out_en = 1'b0;
        bus.reg_pc_inc = 1'b0;
        bus.sp_inc     = 1'b0;
        bus.sp_dec     = 1'b0;
    endtask

    // Inputs are applied at the falling edge; the model steps with the DUT on the rising edge
    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [15:0] val);
        set_idle();
        bus.reg_dst_sel = sel;
        bus.in          = val;
        bus.reg_in_en   = 1'b1;
        tick("write");
        bus.reg_in_en   = 1'b0;
    endtask

    initial begin
        set_idle();
        bus.in          = 16'h0000;
        bus.reg_src_sel = 3'd2;
        bus.reg_dst_sel = 3'd3;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset/pc",  bus.pc,  16'h0100);
        check("reset/sp",  bus.sp,  16'hFFFF);
        check("reset/out", bus.out, zval);
        for (int s = 2; s <= 5; s++) begin
            bus.reg_src_sel = 3'(s);
            bus.reg_dst_sel = 3'(s);
            #1;
            check("reset/alu_a", bus.alu_a, 16'h0000);
            check("reset/alu_b", bus.alu_b, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b1;

        // Fetch increment and wrap
        bus.reg_pc_inc = 1'b1;
        repeat (3) tick("fetch");
        check("fetch/pc3", bus.pc, 16'h0103);
        write_reg(3'd0, 16'hFFFF);
        bus.reg_pc_inc = 1'b1;
        tick("fetch_wrap");
        check("fetch/wrap", bus.pc, 16'h0000);

        // Jump wins over increment
        write_reg(3'd0, 16'h0010);
        bus.in = 16'h0ABC; bus.reg_in_en = 1'b1; bus.reg_pc_inc = 1'b1;
        tick("jump");
        check("jump/pc", bus.pc, 16'h0ABC);

        // Load and read back, no bypass on the write edge
        write_reg(3'd3, 16'h1234);
        bus.reg_src_sel = 3'd3; bus.reg_out_en = 1'b1;
        #1;
        check("load/out",   bus.out,   16'h1234);
        check("load/alu_a", bus.alu_a, 16'h1234);
        bus.reg_out_en = 1'b0;
        #1;
        check("load/out_z", bus.out, zval);

        // Stack pointer stepping, priority and wrap
        set_idle();
        bus.sp_dec = 1'b1;
        repeat (2) tick("sp_dec");
        check("stack/dec2", bus.sp, 16'hFFFD);
        bus.sp_inc = 1'b1;
        tick("sp_both");
        check("stack/both", bus.sp, 16'hFFFD);
        bus.sp_inc = 1'b0;
        bus.reg_dst_sel = 3'd6; bus.in = 16'h8000; bus.reg_in_en = 1'b1;
        tick("sp_load");
        check("stack/load", bus.sp, 16'h8000);
        write_reg(3'd6, 16'h0000);
        bus.sp_dec = 1'b1;
        tick("sp_wrap");
        check("stack/wrap", bus.sp, 16'hFFFF);

        // Move onto itself and copy through the bus
        write_reg(3'd5, 16'h0077);
        set_idle();
        bus.reg_src_sel = 3'd5; bus.reg_dst_sel = 3'd5; bus.reg_out_en = 1'b1;
        #1;
        bus.in = bus.out; bus.reg_in_en = 1'b1;
        tick("move_self");
        check("move/self", bus.alu_a, 16'h0077);
        bus.reg_dst_sel = 3'd2;
        #1;
        bus.in = bus.out;
        tick("move_copy");
        check("move/copy", bus.alu_a, 16'h0077);

        // Asynchronous reset between edges discards the pending write
        write_reg(3'd4, 16'h5555);
        bus.reg_dst_sel = 3'd4; bus.in = 16'hAAAA; bus.reg_in_en = 1'b1;
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("arst/alu_a", bus.alu_a, 16'h0000);
        check("arst/pc",    bus.pc,    16'h0100);
        #1 rst = 1'b1;
        #1;
        check("arst/held", bus.alu_a, 16'h0000);
        bus.reg_in_en = 1'b0;
        tick("arst_after");
        check("arst/after", bus.alu_a, 16'h0000);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            bus.in          = 16'($urandom);
            bus.reg_src_sel = 3'($urandom_range(0, 7));
            bus.reg_dst_sel = 3'($urandom_range(0, 7));
            bus.reg_in_en   = ($urandom_range(0, 9) < 3);
            bus.reg_out_en  = 1'($urandom);
            bus.reg_pc_inc  = 1'($urandom);
            bus.sp_inc      = 1'($urandom);
            bus.sp_dec      = 1'($urandom);
            #1;
            check_all("rand_comb");
            if (bus.reg_in_en && bus.reg_out_en && $urandom_range(0, 1) == 1) bus.in = bus.out;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
